// File: rtl/toy_bus_pkg.sv
// ToyBusReq shared definitions.
// Holds the request field widths, opcode encodings and the node/target ids
// used where request channels fan in. Every other file of this block imports it.
package toy_bus_pkg;

  // ToyBusReq field widths
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_STRB_W = REQ_DATA_W / 8;
  localparam int REQ_ID_W   = 4;

  // Opcode encodings
  localparam logic OPC_RD = 1'b0;
  localparam logic OPC_WR = 1'b1;

  // Node / target ids
  localparam logic [REQ_ID_W-1:0] SRC_FETCH = 4'd1;
  localparam logic [REQ_ID_W-1:0] SRC_LSU   = 4'd2;
  localparam logic [REQ_ID_W-1:0] TGT_MEM   = 4'd0;

  // Input port index used by the two-way arbiter
  typedef enum logic {
    PORT_IN0 = 1'b0,
    PORT_IN1 = 1'b1
  } arb_port_e;

  // Winner on a tie is the favoured port; otherwise the single valid one.
  function automatic logic rr_pick(input logic [1:0] vld, input logic ptr);
    return (&vld) ? ptr : vld[1];
  endfunction

endpackage

// File: rtl/toy_bus_rr_arb2.sv
// Two-input round-robin arbiter with grant lock.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   vld_i[1:0]  request valids of in0/in1
//   adv_i       the granted beat is taken this cycle (moves the pointer, drops the lock)
//   hold_i      the granted beat is stalled this cycle (locks the grant)
//   grant_o     one-hot grant, zero when nothing is requested
//   winner_o    index of the granted (or would-be granted) input, drives the payload mux
//   req_o       a granted request is present
module toy_bus_rr_arb2
  import toy_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] vld_i,
  input  logic       adv_i,
  input  logic       hold_i,
  output logic [1:0] grant_o,
  output logic       winner_o,
  output logic       req_o
);

  logic rr_ptr_q, rr_ptr_d;
  logic lock_vld_q, lock_vld_d;
  logic lock_id_q, lock_id_d;

  always_comb begin
    winner_o = lock_vld_q ? lock_id_q : rr_pick(vld_i, rr_ptr_q);
    // While locked only the locked input can present the beat, so a new
    // valid on the other input never preempts it.
    req_o    = lock_vld_q ? vld_i[lock_id_q] : (|vld_i);
    grant_o  = 2'b00;
    if (req_o) grant_o[winner_o] = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (adv_i) begin
      rr_ptr_d   = ~winner_o;
      lock_vld_d = 1'b0;
    end else if (hold_i) begin
      lock_vld_d = 1'b1;
      lock_id_d  = winner_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= PORT_IN0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= PORT_IN0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end

endmodule

// File: rtl/toy_bus_arb_node_req_rr2.sv
// Two-to-one round-robin merge node for ToyBusReq traffic.
// Grants one beat per handshake from in0/in1 onto the single out channel;
// the payload (addr, strb, data, opcode, src_id, tgt_id) passes unmodified.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   inK_vld / inK_rdy             K=0,1 upstream handshake
//   inK_{addr,strb,data,opcode,src_id,tgt_id}  K=0,1 upstream payload
//   out_vld / out_rdy             downstream handshake
//   out_{addr,strb,data,opcode,src_id,tgt_id}  payload of the granted beat
// Build option TOY_BUS_ARB_OUT_REG_EN: when defined the output is a
// full-throughput register slice (1-cycle latency); otherwise the path is
// combinational with the grant locked while the output is stalled.
module toy_bus_arb_node_req_rr2
  import toy_bus_pkg::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DATA_W = REQ_DATA_W,
  parameter int STRB_W = DATA_W / 8,
  parameter int ID_W   = REQ_ID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [STRB_W-1:0] in0_strb,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_opcode,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [STRB_W-1:0] in1_strb,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_opcode,
  input  logic [ID_W-1:0]   in1_src_id,
  input  logic [ID_W-1:0]   in1_tgt_id,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ADDR_W-1:0] out_addr,
  output logic [STRB_W-1:0] out_strb,
  output logic [DATA_W-1:0] out_data,
  output logic              out_opcode,
  output logic [ID_W-1:0]   out_src_id,
  output logic [ID_W-1:0]   out_tgt_id
);

  localparam int PAY_W = ADDR_W + STRB_W + DATA_W + 1 + 2 * ID_W;

  logic [PAY_W-1:0] pay0, pay1, pay_mux;
  logic [1:0]       grant;
  logic             winner, req, arb_adv, arb_hold;
  logic             run_q;

  assign pay0    = {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id};
  assign pay1    = {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id};
  assign pay_mux = winner ? pay1 : pay0;

  // Cleared asynchronously by reset, set on the first edge after release:
  // keeps out_vld and both rdy low for the whole reset period, including a
  // reset that lands in the middle of a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  toy_bus_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   ({in1_vld, in0_vld}),
    .adv_i   (arb_adv),
    .hold_i  (arb_hold),
    .grant_o (grant),
    .winner_o(winner),
    .req_o   (req)
  );

`ifdef TOY_BUS_ARB_OUT_REG_EN
  logic             acc;
  logic             out_vld_q, out_vld_d;
  logic [PAY_W-1:0] pay_q, pay_d;

  // The slice accepts whenever it is empty or draining this cycle.
  assign acc      = run_q && req && (!out_vld_q || out_rdy);
  assign arb_adv  = acc;
  assign arb_hold = 1'b0;
  assign in0_rdy  = grant[0] && acc;
  assign in1_rdy  = grant[1] && acc;

  always_comb begin
    out_vld_d = out_vld_q;
    pay_d     = pay_q;
    if (out_vld_q && out_rdy) out_vld_d = 1'b0;
    if (acc) begin
      out_vld_d = 1'b1;
      pay_d     = pay_mux;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      pay_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      pay_q     <= pay_d;
    end
  end

  assign out_vld = out_vld_q;
  assign {out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id} = pay_q;
`else
  assign arb_adv  = run_q && req && out_rdy;
  assign arb_hold = run_q && req && !out_rdy;
  assign out_vld  = run_q && req;
  assign in0_rdy  = grant[0] && arb_adv;
  assign in1_rdy  = grant[1] && arb_adv;
  assign {out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id} = pay_mux;
`endif

endmodule

// File: tb/tb_toy_bus_arb_node_req_rr2.sv
module tb_toy_bus_arb_node_req_rr2;

  localparam int PW = 77;  // addr32 strb4 data32 opc1 src4 tgt4

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in0_vld, in0_rdy, in0_opcode, in1_vld, in1_rdy, in1_opcode;
  logic [31:0] in0_addr, in0_data, in1_addr, in1_data;
  logic [3:0]  in0_strb, in0_src_id, in0_tgt_id, in1_strb, in1_src_id, in1_tgt_id;
  logic        out_vld, out_rdy, out_opcode;
  logic [31:0] out_addr, out_data;
  logic [3:0]  out_strb, out_src_id, out_tgt_id;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  toy_bus_arb_node_req_rr2 dut (
    .clk(clk), .rst_n(rst_n),
    .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_strb(in0_strb),
    .in0_data(in0_data), .in0_opcode(in0_opcode), .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id),
    .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_strb(in1_strb),
    .in1_data(in1_data), .in1_opcode(in1_opcode), .in1_src_id(in1_src_id), .in1_tgt_id(in1_tgt_id),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_strb(out_strb),
    .out_data(out_data), .out_opcode(out_opcode), .out_src_id(out_src_id), .out_tgt_id(out_tgt_id)
  );

  wire [PW-1:0] out_pay = {out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id};

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input int k, input logic v, input logic [PW-1:0] p);
    if (k == 0) begin
      in0_vld = v;
      {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id} = p;
    end else begin
      in1_vld = v;
      {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id} = p;
    end
  endtask

  function automatic logic [PW-1:0] addr_pay(input logic [31:0] a);
    return {a, 45'd0};
  endfunction

  function automatic logic [PW-1:0] rand_pay();
    return {32'($urandom), 4'($urandom), 32'($urandom), 1'($urandom), 4'($urandom), 4'($urandom)};
  endfunction

  // ---------------- reference model ----------------
  bit           pend[2];
  logic [PW-1:0] pay[2];
  bit           m_ptr;
`ifdef TOY_BUS_ARB_OUT_REG_EN
  bit            m_ovld;
  logic [PW-1:0] m_pay;
`else
  bit            m_lock;
  bit            m_lid;
`endif

  // One cycle of randomized upstream traffic checked against the model.
  task automatic rnd_cycle(input bit gen, input bit ordy_rand);
    bit any, g, ordy, ev, acc;
    bit er[2];
    logic [PW-1:0] ep;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      if (gen && !pend[k] && $urandom_range(0, 99) < 60) begin
        pend[k] = 1'b1;
        pay[k]  = rand_pay();
      end
    set_in(0, pend[0], pay[0]);
    set_in(1, pend[1], pay[1]);
    ordy = ordy_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
    out_rdy = ordy;
    #2;
    any = pend[0] || pend[1];
`ifdef TOY_BUS_ARB_OUT_REG_EN
    g   = (pend[0] && pend[1]) ? m_ptr : pend[1];
    acc = any && (!m_ovld || ordy);
    ev  = m_ovld;
    ep  = m_pay;
`else
    g   = m_lock ? m_lid : ((pend[0] && pend[1]) ? m_ptr : pend[1]);
    acc = any && ordy;
    ev  = any;
    ep  = pay[g];
`endif
    er[0] = acc && (g == 1'b0);
    er[1] = acc && (g == 1'b1);
    chk("rnd_out_vld", PW'(out_vld), PW'(ev));
    chk("rnd_in0_rdy", PW'(in0_rdy), PW'(er[0]));
    chk("rnd_in1_rdy", PW'(in1_rdy), PW'(er[1]));
    if (ev) chk("rnd_payload", out_pay, ep);
    // advance the model to the state after the coming edge
`ifdef TOY_BUS_ARB_OUT_REG_EN
    if (m_ovld && ordy) m_ovld = 1'b0;
    if (acc) begin
      m_ovld = 1'b1;
      m_pay  = pay[g];
      m_ptr  = !g;
      pend[g] = 1'b0;
    end
`else
    if (acc) begin
      m_ptr   = !g;
      m_lock  = 1'b0;
      pend[g] = 1'b0;
    end else if (any) begin
      m_lock = 1'b1;
      m_lid  = g;
    end
`endif
  endtask

  typedef struct {
    logic        v0, v1, ordy;
    logic        ev, er0, er1;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // -------- reset with both requesters valid --------
    rst_n = 1'b0;
    out_rdy = 1'b1;
    set_in(0, 1'b1, addr_pay(32'h100));
    set_in(1, 1'b1, addr_pay(32'h200));
    repeat (2) @(negedge clk);
    #2;
    chk("reset_out_vld", PW'(out_vld), '0);
    chk("reset_in0_rdy", PW'(in0_rdy), '0);
    chk("reset_in1_rdy", PW'(in1_rdy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("first_grant_in0_rdy", PW'(in0_rdy), PW'(1'b1));
    chk("first_grant_in1_rdy", PW'(in1_rdy), '0);
    #1;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);

`ifndef TOY_BUS_ARB_OUT_REG_EN
    // -------- table: alternation, stall lock, single requester, idle --------
    tbl[0]  = '{1, 1, 1, 1, 1, 0, 32'h100};
    tbl[1]  = '{1, 1, 1, 1, 0, 1, 32'h200};
    tbl[2]  = '{1, 1, 1, 1, 1, 0, 32'h100};
    tbl[3]  = '{1, 1, 1, 1, 0, 1, 32'h200};
    tbl[4]  = '{0, 1, 0, 1, 0, 0, 32'h200};  // in1 granted, stalled
    tbl[5]  = '{1, 1, 0, 1, 0, 0, 32'h200};  // in0 rises, lock holds
    tbl[6]  = '{1, 1, 0, 1, 0, 0, 32'h200};
    tbl[7]  = '{1, 1, 1, 1, 0, 1, 32'h200};  // locked beat drains
    tbl[8]  = '{1, 1, 1, 1, 1, 0, 32'h100};  // next grant to in0
    tbl[9]  = '{0, 1, 1, 1, 0, 1, 32'h200};
    tbl[10] = '{0, 1, 1, 1, 0, 1, 32'h200};
    tbl[11] = '{0, 1, 1, 1, 0, 1, 32'h200};
    tbl[12] = '{0, 1, 1, 1, 0, 1, 32'h200};
    tbl[13] = '{0, 1, 1, 1, 0, 1, 32'h200};
    tbl[14] = '{1, 1, 1, 1, 1, 0, 32'h100};  // in0 wins after in1-only run
    tbl[15] = '{0, 0, 1, 0, 0, 0, 32'h0};    // idle, pointer held
    tbl[16] = '{1, 1, 1, 1, 0, 1, 32'h200};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      set_in(0, tbl[i].v0, addr_pay(32'h100));
      set_in(1, tbl[i].v1, addr_pay(32'h200));
      out_rdy = tbl[i].ordy;
      #2;
      chk($sformatf("tbl%0d_out_vld", i), PW'(out_vld), PW'(tbl[i].ev));
      chk($sformatf("tbl%0d_in0_rdy", i), PW'(in0_rdy), PW'(tbl[i].er0));
      chk($sformatf("tbl%0d_in1_rdy", i), PW'(in1_rdy), PW'(tbl[i].er1));
      if (tbl[i].ev) chk($sformatf("tbl%0d_out_addr", i), PW'(out_addr), PW'(tbl[i].ea));
    end
    m_ptr  = 1'b0;
    m_lock = 1'b0;
    m_lid  = 1'b0;
`else
    m_ptr  = 1'b0;
    m_ovld = 1'b0;
    m_pay  = '0;
`endif

    // -------- randomized traffic against the model --------
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    pay[0]  = '0;
    pay[1]  = '0;
    for (int c = 0; c < 400; c++) rnd_cycle(1'b1, 1'b1);
    for (int c = 0; c < 4; c++) rnd_cycle(1'b0, 1'b0);

    // -------- async reset in the middle of a stall --------
    @(negedge clk);
    set_in(0, 1'b1, addr_pay(32'h100));
    set_in(1, 1'b0, '0);
    out_rdy = 1'b1;                           // in0 beat taken -> pointer favours in1
    @(negedge clk);
    set_in(1, 1'b1, addr_pay(32'h200));
    out_rdy = 1'b0;
    @(negedge clk);
    #2;
    chk("stall_out_vld", PW'(out_vld), PW'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_vld", PW'(out_vld), '0);
    chk("async_rst_in1_rdy", PW'(in1_rdy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("post_rst_in0_rdy", PW'(in0_rdy), PW'(1'b1));
    chk("post_rst_in1_rdy", PW'(in1_rdy), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
